// File: rtl/rx_frame_sequencer.sv
// UART receive sequencer: start-bit detect/validate, mid-bit shift strobes, stop-bit check.
// Optional RX_OVERRUN_EN adds buffer_full input and sticky overrun_error output.
module rx_frame_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned NUM_BITS     = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
`ifdef RX_OVERRUN_EN
  ,
  input  logic buffer_full,
  output logic overrun_error
`endif
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECV      = 3'd2,
    CHECK     = 3'd3,
    LOAD      = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
  logic             prev_in;
  logic             framing_error_next;
`ifdef RX_OVERRUN_EN
  logic             overrun_error_next;
`endif

  // State register, counters, edge-detect history and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      prev_in       <= 1'b1;
      framing_error <= 1'b0;
`ifdef RX_OVERRUN_EN
      overrun_error <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      clk_cnt       <= clk_cnt_next;
      bit_cnt       <= bit_cnt_next;
      prev_in       <= serial_in;
      framing_error <= framing_error_next;
`ifdef RX_OVERRUN_EN
      overrun_error <= overrun_error_next;
`endif
    end
  end

  // Next-state and counter/flag update logic
  always_comb begin
    state_next         = state;
    clk_cnt_next       = clk_cnt;
    bit_cnt_next       = bit_cnt;
    framing_error_next = framing_error;
`ifdef RX_OVERRUN_EN
    overrun_error_next = overrun_error;
`endif
    unique case (state)
      IDLE: begin
        if (prev_in && !serial_in) begin
          state_next   = START_CHK;
          clk_cnt_next = '0;
        end
      end
      START_CHK: begin
        if (clk_cnt == CNT_W'(HALF - 1)) begin
          if (serial_in) begin
            state_next = IDLE;
          end else begin
            state_next         = RECV;
            clk_cnt_next       = '0;
            bit_cnt_next       = '0;
            framing_error_next = 1'b0;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      RECV: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_next = '0;
          bit_cnt_next = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(NUM_BITS - 1)) state_next = CHECK;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (stop_bit) begin
          state_next = LOAD;
        end else begin
          state_next         = IDLE;
          framing_error_next = 1'b1;
        end
      end
      LOAD: begin
        state_next = IDLE;
`ifdef RX_OVERRUN_EN
        overrun_error_next = buffer_full;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and counters
  always_comb begin
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    rx_busy      = (state != IDLE);
    if (state == RECV && clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) shift_strobe = 1'b1;
    if (state == LOAD) load_buffer = 1'b1;
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed testbench for rx_frame_sequencer (CLKS_PER_BIT=10) with a behavioural 9-bit shift register.
module tb_rx_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic stop_bit;
  logic shift_strobe, load_buffer, framing_error, rx_busy;
  logic [8:0] sr = 9'h000;
`ifdef RX_OVERRUN_EN
  logic buffer_full = 1'b0;
  logic overrun_error;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_frame_sequencer #(.CLKS_PER_BIT(10), .NUM_BITS(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .stop_bit      (stop_bit),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
`ifdef RX_OVERRUN_EN
    ,
    .buffer_full   (buffer_full),
    .overrun_error (overrun_error)
`endif
  );

  // Shift register model: shift mid-cycle so the strobe is sampled stably
  always @(negedge clk) if (shift_strobe === 1'b1) sr <= {serial_in, sr[8:1]};
  assign stop_bit = sr[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_level(input logic [7:0] data, input logic stop, input int i);
    if (i < 10) return 1'b0;
    if (i < 90) return data[(i / 10) - 1];
    return stop;
  endfunction

  // One frame starting at cycle E (i=0); ends after cycle E+97, leaving the line at stop level
  task automatic test_frame(input logic [7:0] data, input logic stop, input logic fe_before);
    logic exp_s, exp_l, exp_b, exp_fe;
    int   strobes = 0;
    for (int i = 0; i <= 97; i++) begin
      serial_in = line_level(data, stop, i);
      exp_s  = (i >= 15) && (i <= 95) && ((i - 15) % 10 == 0);
      exp_l  = stop && (i == 97);
      exp_b  = (i >= 1) && (i <= (stop ? 97 : 96));
      exp_fe = (i <= 5) ? fe_before : ((i >= 97) ? !stop : 1'b0);
      n_checks += 4;
      if (shift_strobe !== exp_s) begin
        n_fail++; $display("FAIL frame%02h strobe i=%0d got %b want %b", data, i, shift_strobe, exp_s);
      end
      if (load_buffer !== exp_l) begin
        n_fail++; $display("FAIL frame%02h load i=%0d got %b want %b", data, i, load_buffer, exp_l);
      end
      if (rx_busy !== exp_b) begin
        n_fail++; $display("FAIL frame%02h busy i=%0d got %b want %b", data, i, rx_busy, exp_b);
      end
      if (framing_error !== exp_fe) begin
        n_fail++; $display("FAIL frame%02h ferr i=%0d got %b want %b", data, i, framing_error, exp_fe);
      end
      if (shift_strobe === 1'b1) strobes++;
      tick();
    end
    n_checks += 2;
    if (strobes != 9) begin
      n_fail++; $display("FAIL frame%02h strobe_count got %0d want 9", data, strobes);
    end
    if (sr !== {stop, data}) begin
      n_fail++; $display("FAIL frame%02h captured got %h want %h", data, sr, {stop, data});
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks += 4;
    if (shift_strobe !== 1'b0) begin n_fail++; $display("FAIL reset strobe got %b want 0", shift_strobe); end
    if (load_buffer !== 1'b0) begin n_fail++; $display("FAIL reset load got %b want 0", load_buffer); end
    if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset ferr got %b want 0", framing_error); end
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", rx_busy); end
`ifdef RX_OVERRUN_EN
    n_checks++;
    if (overrun_error !== 1'b0) begin n_fail++; $display("FAIL reset overrun got %b want 0", overrun_error); end
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (shift_strobe !== 1'b0 || rx_busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle i=%0d strobe %b busy %b want 0 0", i, shift_strobe, rx_busy);
      end
    end
  endtask

  task automatic test_good_frame();
    test_frame(8'hA5, 1'b1, 1'b0);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL good busy_after got %b want 0", rx_busy); end
    idle(5);
  endtask

  task automatic test_glitch();
    logic exp_b;
    for (int i = 0; i < 30; i++) begin
      serial_in = (i < 3) ? 1'b0 : 1'b1;
      exp_b = (i >= 1) && (i <= 5);
      n_checks += 3;
      if (rx_busy !== exp_b) begin n_fail++; $display("FAIL glitch busy i=%0d got %b want %b", i, rx_busy, exp_b); end
      if (shift_strobe !== 1'b0) begin n_fail++; $display("FAIL glitch strobe i=%0d got %b want 0", i, shift_strobe); end
      if (load_buffer !== 1'b0) begin n_fail++; $display("FAIL glitch load i=%0d got %b want 0", i, load_buffer); end
      tick();
    end
  endtask

  task automatic test_framing_error();
    test_frame(8'h3C, 1'b0, 1'b0);
    idle(5);
    n_checks++;
    if (framing_error !== 1'b1) begin n_fail++; $display("FAIL ferr sticky got %b want 1", framing_error); end
    test_frame(8'hC3, 1'b1, 1'b1);
    idle(5);
  endtask

  task automatic test_reset_mid_frame();
    int strobes = 0;
    for (int i = 0; i <= 46; i++) begin
      serial_in = line_level(8'h5A, 1'b1, i);
      if (shift_strobe === 1'b1) strobes++;
      if (i == 46) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    serial_in = 1'b1;
    n_checks += 5;
    if (strobes != 4) begin n_fail++; $display("FAIL midrst strobes_before got %0d want 4", strobes); end
    if (shift_strobe !== 1'b0) begin n_fail++; $display("FAIL midrst strobe got %b want 0", shift_strobe); end
    if (load_buffer !== 1'b0) begin n_fail++; $display("FAIL midrst load got %b want 0", load_buffer); end
    if (framing_error !== 1'b0) begin n_fail++; $display("FAIL midrst ferr got %b want 0", framing_error); end
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy got %b want 0", rx_busy); end
    for (int i = 0; i < 80; i++) begin
      tick();
      n_checks++;
      if (shift_strobe !== 1'b0 || load_buffer !== 1'b0 || rx_busy !== 1'b0) begin
        n_fail++; $display("FAIL midrst_idle i=%0d strobe %b load %b busy %b want 0 0 0", i, shift_strobe, load_buffer, rx_busy);
      end
    end
    test_frame(8'h5A, 1'b1, 1'b0);
    idle(5);
  endtask

  task automatic test_back_to_back();
    test_frame(8'h11, 1'b1, 1'b0);
    test_frame(8'h80, 1'b1, 1'b0);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b busy_after got %b want 0", rx_busy); end
    idle(5);
  endtask

`ifdef RX_OVERRUN_EN
  task automatic test_overrun();
    buffer_full = 1'b0;
    test_frame(8'h21, 1'b1, 1'b0);
    n_checks++;
    if (overrun_error !== 1'b0) begin n_fail++; $display("FAIL overrun first got %b want 0", overrun_error); end
    buffer_full = 1'b1;
    test_frame(8'h42, 1'b1, 1'b0);
    buffer_full = 1'b0;
    idle(3);
    n_checks++;
    if (overrun_error !== 1'b1) begin n_fail++; $display("FAIL overrun set got %b want 1", overrun_error); end
    test_frame(8'h84, 1'b1, 1'b0);
    n_checks++;
    if (overrun_error !== 1'b0) begin n_fail++; $display("FAIL overrun clear got %b want 0", overrun_error); end
    idle(5);
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef RX_OVERRUN_EN
    test_overrun();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
